// File: rtl/tempo_pkg.sv
// rtl/tempo_pkg.sv - shared types, default tempo constants and the step arithmetic for tempo_ctrl
package tempo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    HOLD,
    REPEAT,
    DEB_REL
  } tempo_state_t;

  typedef logic [1:0] btn_code_t;

  localparam btn_code_t CODE_NONE = 2'b00;
  localparam btn_code_t CODE_DEC  = 2'b01;
  localparam btn_code_t CODE_INC  = 2'b10;
  localparam btn_code_t CODE_BOTH = 2'b11;

  localparam int BPM_INIT_DEF = 120;
  localparam int BPM_MIN_DEF  = 40;
  localparam int BPM_MAX_DEF  = 240;
  localparam int BPM_STEP_DEF = 10;

  // 9-bit intermediates so a step past either end clamps instead of wrapping
  function automatic logic [7:0] next_bpm(input btn_code_t code, input logic [7:0] cur,
                                          input logic [7:0] init, input logic [7:0] lo,
                                          input logic [7:0] hi, input logic [7:0] step);
    logic [8:0] sum;
    logic [8:0] diff;
    sum  = {1'b0, cur} + {1'b0, step};
    diff = {1'b0, cur} - {1'b0, step};
    case (code)
      CODE_INC:  next_bpm = (sum > {1'b0, hi}) ? hi : sum[7:0];
      CODE_DEC:  next_bpm = (diff[8] || (diff[7:0] < lo)) ? lo : diff[7:0];
      CODE_BOTH: next_bpm = init;
      default:   next_bpm = cur;
    endcase
  endfunction

endpackage

// File: rtl/btn_sync.sv
// rtl/btn_sync.sv - parameterised-width two-flop synchroniser for raw button levels
module btn_sync #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/tempo_ctrl.sv
// rtl/tempo_ctrl.sv - debounced +/- tempo buttons with clamping, both-button restore and load strobe
// TEMPO_AUTOREPEAT_EN: when defined, a held inc/dec button auto-repeats after HOLD_CYC.
module tempo_ctrl
  import tempo_pkg::*;
#(
  parameter int BPM_INIT     = BPM_INIT_DEF,
  parameter int BPM_MIN      = BPM_MIN_DEF,
  parameter int BPM_MAX      = BPM_MAX_DEF,
  parameter int BPM_STEP     = BPM_STEP_DEF,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int HOLD_CYC     = 25_000_000,
  parameter int REPEAT_CYC   = 5_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       botao1,
  input  logic       botao2,
  output logic [7:0] bpm,
  output logic       bpm_load,
  output logic       lim_min,
  output logic       lim_max
);

  localparam int CYC_A   = (DEBOUNCE_CYC > HOLD_CYC) ? DEBOUNCE_CYC : HOLD_CYC;
  localparam int CYC_MAX = (CYC_A > REPEAT_CYC) ? CYC_A : REPEAT_CYC;
  localparam int CNT_W   = (CYC_MAX > 1) ? $clog2(CYC_MAX) : 1;

  // The entry edge into a debounce state already consumed the first stable cycle
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 2);
`ifdef TEMPO_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYC - 1);
`endif

  btn_code_t    code;
  btn_code_t    code_q;
  tempo_state_t state;
  logic [CNT_W-1:0] cnt;
  logic [7:0]   bpm_next;
  logic         init_pending;

  btn_sync #(.WIDTH(2)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   ({botao2, botao1}),
    .q   (code)
  );

  assign bpm_next = next_bpm(code_q, bpm, 8'(BPM_INIT), 8'(BPM_MIN), 8'(BPM_MAX), 8'(BPM_STEP));

  assign lim_min = (bpm == 8'(BPM_MIN));
  assign lim_max = (bpm == 8'(BPM_MAX));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      code_q       <= CODE_NONE;
      cnt          <= '0;
      bpm          <= 8'(BPM_INIT);
      bpm_load     <= 1'b0;
      init_pending <= 1'b1;
    end else begin
      // First edge out of reset tells the divider to load the initial tempo
      bpm_load     <= init_pending;
      init_pending <= 1'b0;
      case (state)
        IDLE: begin
          if (code != CODE_NONE) begin
            code_q <= code;
            cnt    <= '0;
            state  <= DEB_PRESS;
          end
        end
        DEB_PRESS: begin
          if (code != code_q) begin
            state <= IDLE;
          end else if (cnt == DEB_LAST) begin
            if (bpm_next != bpm) begin
              bpm      <= bpm_next;
              bpm_load <= 1'b1;
            end
            cnt   <= '0;
            state <= HOLD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        HOLD, REPEAT: begin
          if (code == CODE_NONE) begin
            cnt   <= '0;
            state <= DEB_REL;
          end else if (code != code_q) begin
            code_q <= code;
            cnt    <= '0;
            state  <= DEB_PRESS;
          end
`ifdef TEMPO_AUTOREPEAT_EN
          else if ((code_q != CODE_BOTH) &&
                   (cnt == ((state == HOLD) ? HOLD_LAST : REP_LAST))) begin
            if (bpm_next != bpm) begin
              bpm      <= bpm_next;
              bpm_load <= 1'b1;
            end
            cnt   <= '0;
            state <= REPEAT;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
`endif
        end
        DEB_REL: begin
          // Release bounce drops back to HOLD without stepping again
          if (code != CODE_NONE) begin
            cnt   <= '0;
            state <= HOLD;
          end else if (cnt == DEB_LAST) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tempo_ctrl.sv
// tb/tb_tempo_ctrl.sv - self-checking bench for tempo_ctrl with a load-event scoreboard
module tb_tempo_ctrl;

  localparam int DEB   = 4;
  localparam int HOLDC = 20;
  localparam int REP   = 8;
  localparam int LAT   = DEB + 2;

  typedef struct {
    int         cyc;
    logic [7:0] bpm;
  } ev_t;

  typedef struct {
    int         d;
    logic [1:0] code;
    int         len;
    logic [7:0] exp_bpm;
    bit         exp_load;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] b1 = '0;
  logic [2:0] b2 = '0;
  logic [7:0] bpm_o  [3];
  logic       load_o [3];
  logic       lmin_o [3];
  logic       lmax_o [3];
  logic [7:0] init_v [3] = '{8'd120, 8'd235, 8'd40};

  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  ev_t  sbq[3][$];
  vec_t vecs[$];
  int   p;
  logic [7:0] cur;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  tempo_ctrl #(.BPM_INIT(120), .DEBOUNCE_CYC(DEB), .HOLD_CYC(HOLDC), .REPEAT_CYC(REP)) u0 (
    .clk(clk), .rst(rst), .botao1(b1[0]), .botao2(b2[0]),
    .bpm(bpm_o[0]), .bpm_load(load_o[0]), .lim_min(lmin_o[0]), .lim_max(lmax_o[0]));

  tempo_ctrl #(.BPM_INIT(235), .DEBOUNCE_CYC(DEB), .HOLD_CYC(HOLDC), .REPEAT_CYC(REP)) u1 (
    .clk(clk), .rst(rst), .botao1(b1[1]), .botao2(b2[1]),
    .bpm(bpm_o[1]), .bpm_load(load_o[1]), .lim_min(lmin_o[1]), .lim_max(lmax_o[1]));

  tempo_ctrl #(.BPM_INIT(40), .DEBOUNCE_CYC(DEB), .HOLD_CYC(HOLDC), .REPEAT_CYC(REP)) u2 (
    .clk(clk), .rst(rst), .botao1(b1[2]), .botao2(b2[2]),
    .bpm(bpm_o[2]), .bpm_load(load_o[2]), .lim_min(lmin_o[2]), .lim_max(lmax_o[2]));

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_state(input int d, input logic [7:0] exp, input string tag);
    check($sformatf("%s_u%0d_bpm", tag, d), int'(bpm_o[d]), int'(exp));
    check($sformatf("%s_u%0d_lim_min", tag, d), int'(lmin_o[d]), int'(exp == 8'd40));
    check($sformatf("%s_u%0d_lim_max", tag, d), int'(lmax_o[d]), int'(exp == 8'd240));
  endtask

  // Every bpm_load must match the oldest expected event in cycle and value
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      while (sbq[d].size() > 0 && sbq[d][0].cyc < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL missed_load_u%0d: no pulse at cycle %0d, expected bpm %0d",
                 d, sbq[d][0].cyc, sbq[d][0].bpm);
        void'(sbq[d].pop_front());
      end
      if (load_o[d]) begin
        if (sbq[d].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_load_u%0d: pulse at cycle %0d with bpm %0d, expected none",
                   d, cyc, bpm_o[d]);
        end else begin
          ev_t ev;
          ev = sbq[d].pop_front();
          check($sformatf("load_cycle_u%0d", d), cyc, ev.cyc);
          check($sformatf("load_bpm_u%0d", d), int'(bpm_o[d]), int'(ev.bpm));
        end
      end
    end
  end

  task automatic press(input int d, input logic [1:0] code, input int len,
                       input logic [7:0] exp_bpm, input bit exp_load, input string tag);
    @(posedge clk); #2;
    if (exp_load) sbq[d].push_back(ev_t'{cyc + LAT, exp_bpm});
    b1[d] = code[0];
    b2[d] = code[1];
    repeat (len) @(posedge clk);
    #2;
    b1[d] = 1'b0;
    b2[d] = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    check_state(d, exp_bpm, tag);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check_state(d, init_v[d], "reset");
      check($sformatf("reset_u%0d_load", d), int'(load_o[d]), 0);
    end
    @(posedge clk); #2;
    for (int d = 0; d < 3; d++) sbq[d].push_back(ev_t'{cyc + 1, init_v[d]});
    rst = 1'b0;
    repeat (6) @(posedge clk);

    vecs.push_back('{0, 2'b10, 10, 8'd130, 1'b1});
    vecs.push_back('{0, 2'b01, 10, 8'd120, 1'b1});
    vecs.push_back('{0, 2'b10,  2, 8'd120, 1'b0});
    vecs.push_back('{0, 2'b10,  3, 8'd120, 1'b0});
    vecs.push_back('{0, 2'b10,  4, 8'd130, 1'b1});
    vecs.push_back('{0, 2'b01,  4, 8'd120, 1'b1});
    vecs.push_back('{0, 2'b11, 10, 8'd120, 1'b0});
    vecs.push_back('{0, 2'b10, 10, 8'd130, 1'b1});
    vecs.push_back('{0, 2'b11, 10, 8'd120, 1'b1});
    vecs.push_back('{1, 2'b10, 10, 8'd240, 1'b1});
    vecs.push_back('{1, 2'b10, 10, 8'd240, 1'b0});
    vecs.push_back('{1, 2'b01, 10, 8'd230, 1'b1});
    vecs.push_back('{1, 2'b11, 10, 8'd235, 1'b1});
    vecs.push_back('{2, 2'b01, 10, 8'd40,  1'b0});
    vecs.push_back('{2, 2'b10, 10, 8'd50,  1'b1});
    vecs.push_back('{2, 2'b01, 10, 8'd40,  1'b1});
    vecs.push_back('{2, 2'b01, 10, 8'd40,  1'b0});
    foreach (vecs[i])
      press(vecs[i].d, vecs[i].code, vecs[i].len, vecs[i].exp_bpm, vecs[i].exp_load,
            $sformatf("vec%0d", i));

    // bounce train: never four consecutive high samples
    @(posedge clk); #2;
    for (int i = 0; i < 6; i++) begin
      b2[0] = (i % 2 == 0);
      @(posedge clk); #2;
    end
    b2[0] = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    check_state(0, 8'd120, "bounce");

    // held inc from 120
    @(posedge clk); #2;
    p = cyc;
    sbq[0].push_back(ev_t'{p + LAT, 8'd130});
`ifdef TEMPO_AUTOREPEAT_EN
    sbq[0].push_back(ev_t'{p + LAT + HOLDC, 8'd140});
    for (int k = 1; k <= 3; k++)
      sbq[0].push_back(ev_t'{p + LAT + HOLDC + k * REP, 8'(140 + 10 * k)});
    cur = 8'd170;
`else
    cur = 8'd130;
`endif
    b2[0] = 1'b1;
    repeat (52) @(posedge clk);
    #2;
    b2[0] = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    check_state(0, cur, "autorep");

    while (cur < 8'd180) begin
      cur = cur + 8'd10;
      press(0, 2'b10, 10, cur, 1'b1, "climb");
    end

    // at 180: inc then add dec -> restore, no repeats while both held
    @(posedge clk); #2;
    sbq[0].push_back(ev_t'{cyc + LAT, 8'd190});
    b2[0] = 1'b1;
    repeat (10) @(posedge clk);
    #2;
    sbq[0].push_back(ev_t'{cyc + LAT, 8'd120});
    b1[0] = 1'b1;
    repeat (30) @(posedge clk);
    #2;
    b1[0] = 1'b0;
    b2[0] = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    check_state(0, 8'd120, "both");

    // reset while repeating, button kept held through reset
    @(posedge clk); #2;
    p = cyc;
    sbq[0].push_back(ev_t'{p + LAT, 8'd130});
`ifdef TEMPO_AUTOREPEAT_EN
    sbq[0].push_back(ev_t'{p + LAT + HOLDC, 8'd140});
`endif
    b2[0] = 1'b1;
    repeat (30) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_bpm", int'(bpm_o[0]), 120);
    check("async_rst_load", int'(load_o[0]), 0);
    check("async_rst_u1_bpm", int'(bpm_o[1]), 235);
    repeat (3) @(posedge clk);
    #2;
    for (int d = 0; d < 3; d++) sbq[d].push_back(ev_t'{cyc + 1, init_v[d]});
    sbq[0].push_back(ev_t'{cyc + LAT, 8'd130});
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    b2[0] = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    check_state(0, 8'd130, "post_rst");

    repeat (4) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++)
      check($sformatf("pending_loads_u%0d", d), sbq[d].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
